// File: rtl/ffm_pkg.sv
// ---------------------------------------------------------------------------
// ffm_pkg
//   Types shared by the frame-former (FFM) blocks.
//   ffm_gate_state_t : state of the frame gate
//     BLOCKED - stream is held closed while waiting for fill threshold/timeout
//     OPEN    - exactly one frame is passing; closes on the tlast handshake
//     BYPASS  - gating disabled; frame-aligned pass-through
// ---------------------------------------------------------------------------
package ffm_pkg;

  typedef enum logic [1:0] {
    BLOCKED = 2'd0,
    OPEN    = 2'd1,
    BYPASS  = 2'd2
  } ffm_gate_state_t;

endpackage : ffm_pkg

// File: rtl/ffm_sat_counter.sv
// ---------------------------------------------------------------------------
// ffm_sat_counter
//   Synchronous-reset saturating event counter. Counts one per cycle while
//   inc is high and holds at all-ones once reached.
// Ports:
//   ACLK    in  clock
//   ARESETN in  synchronous active-low reset (clears the count)
//   inc     in  increment request for this cycle
//   count   out current count (registered)
// ---------------------------------------------------------------------------
module ffm_sat_counter #(
  parameter int W = 32
) (
  input  logic         ACLK,
  input  logic         ARESETN,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign count = cnt_q;

endmodule : ffm_sat_counter

// File: rtl/ffm_frame_gate.sv
// ---------------------------------------------------------------------------
// ffm_frame_gate
//   Frame-granular AXI-Stream valid/ready gate in front of the FFS buffer.
//   While BLOCKED the stream is held closed until FFSTail >= Delay, or until
//   Timeout cycles have been spent waiting (Timeout = 0 disables this). The
//   gate then passes exactly one frame, up to and including the tlast
//   handshake, and closes again. Enable = 0 selects a frame-aligned bypass.
//   Only tvalid/tready are gated; tdata/tkeep are routed outside this block.
//
// Handshake: a beat transfers in a cycle where S_AXIS_tvalid, M_AXIS_tready
//   and the registered pass flag are all high (hs). A frame ends on the
//   handshake of a beat carrying S_AXIS_tlast (fe). A stalled tlast beat
//   (valid without ready) does not end the frame.
//
// Ports:
//   ACLK, ARESETN     clock, synchronous active-low reset
//   Enable            1 = gating active, 0 = bypass
//   Delay             fill threshold (AW+1 bits, unsigned)
//   Timeout           max BLOCKED cycles before forced release, 0 = off
//   FFSTail           current FFS tail/occupancy (AW+1 bits, unsigned)
//   S_AXIS_tvalid/tlast, M_AXIS_tready   upstream valid/last, downstream ready
//   M_AXIS_tvalid, S_AXIS_tready         gated valid / ready
//   Gate_open         registered pass flag
//   Frames_released   frames ended in OPEN (saturating)
//   Timeout_releases  releases caused by timeout (saturating)
// ---------------------------------------------------------------------------
module ffm_frame_gate
  import ffm_pkg::*;
#(
  parameter int MAX_INTERNAL_SPACE = 64,
  parameter int TIMEOUT_W          = 16,
  parameter int CNT_W              = 32,
  localparam int AW                = $clog2(MAX_INTERNAL_SPACE)
) (
  input  logic                 ACLK,
  input  logic                 ARESETN,
  input  logic                 Enable,
  input  logic [AW:0]          Delay,
  input  logic [TIMEOUT_W-1:0] Timeout,
  input  logic [AW:0]          FFSTail,
  input  logic                 S_AXIS_tvalid,
  input  logic                 S_AXIS_tlast,
  input  logic                 M_AXIS_tready,
  output logic                 M_AXIS_tvalid,
  output logic                 S_AXIS_tready,
  output logic                 Gate_open,
  output logic [CNT_W-1:0]     Frames_released,
  output logic [CNT_W-1:0]     Timeout_releases
);

  ffm_gate_state_t      state_q;
  logic                 gate_open_q;   // always equals (state_q != BLOCKED)
  logic [TIMEOUT_W-1:0] wait_cnt_q;
  logic                 in_frame_q;

  logic                 hs;
  logic                 fe;
  logic                 hs_mid;
  logic                 thresh_hit;
  logic                 tmo_hit;
  logic [TIMEOUT_W-1:0] tmo_m1;
  logic                 frame_inc;
  logic                 tmo_inc;

  assign hs         = S_AXIS_tvalid & M_AXIS_tready & gate_open_q;
  assign fe         = hs & S_AXIS_tlast;
  assign hs_mid     = hs & ~S_AXIS_tlast;

  // Release conditions only feed the next-state logic, never the outputs.
  assign thresh_hit = (FFSTail >= Delay);
  assign tmo_m1     = Timeout - TIMEOUT_W'(1);
  assign tmo_hit    = (Timeout != '0) && (wait_cnt_q == tmo_m1);

  // Threshold wins over timeout, so a simultaneous hit is not a timeout release.
  assign frame_inc  = (state_q == OPEN) & fe;
  assign tmo_inc    = (state_q == BLOCKED) & Enable & ~thresh_hit & tmo_hit;

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q     <= BLOCKED;
      gate_open_q <= 1'b0;
      wait_cnt_q  <= '0;
      in_frame_q  <= 1'b0;
    end else begin
      case (state_q)
        BLOCKED: begin
          in_frame_q <= 1'b0;
          if (!Enable) begin
            state_q     <= BYPASS;
            gate_open_q <= 1'b1;
            wait_cnt_q  <= '0;
          end else if (thresh_hit || tmo_hit) begin
            state_q     <= OPEN;
            gate_open_q <= 1'b1;
            wait_cnt_q  <= '0;
          end else begin
            wait_cnt_q  <= wait_cnt_q + TIMEOUT_W'(1);
          end
        end

        OPEN: begin
          wait_cnt_q <= '0;
          in_frame_q <= 1'b0;
          // Enable is only looked at on the frame end, so a frame in flight
          // is never cut short.
          if (fe) begin
            if (Enable) begin
              state_q     <= BLOCKED;
              gate_open_q <= 1'b0;
            end else begin
              state_q     <= BYPASS;
              gate_open_q <= 1'b1;
            end
          end
        end

        BYPASS: begin
          wait_cnt_q <= '0;
          // Leave bypass only between frames: either idle (no frame in
          // progress and none starting now) or on the closing handshake.
          if (Enable && (fe || (!in_frame_q && !hs_mid))) begin
            state_q     <= BLOCKED;
            gate_open_q <= 1'b0;
            in_frame_q  <= 1'b0;
          end else if (fe) begin
            in_frame_q  <= 1'b0;
          end else if (hs_mid) begin
            in_frame_q  <= 1'b1;
          end
        end

        default: begin
          state_q     <= BLOCKED;
          gate_open_q <= 1'b0;
          wait_cnt_q  <= '0;
          in_frame_q  <= 1'b0;
        end
      endcase
    end
  end

  assign M_AXIS_tvalid = S_AXIS_tvalid & gate_open_q;
  assign S_AXIS_tready = M_AXIS_tready & gate_open_q;
  assign Gate_open     = gate_open_q;

  ffm_sat_counter #(.W(CNT_W)) u_frames_cnt (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .inc     (frame_inc),
    .count   (Frames_released)
  );

  ffm_sat_counter #(.W(CNT_W)) u_tmo_cnt (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .inc     (tmo_inc),
    .count   (Timeout_releases)
  );

endmodule : ffm_frame_gate

// File: tb/tb_ffm_frame_gate.sv
// ---------------------------------------------------------------------------
// tb_ffm_frame_gate
//   Directed bench for ffm_frame_gate. Inputs change on the falling edge and
//   outputs are checked 1 ns later, i.e. within the same clock cycle.
// ---------------------------------------------------------------------------
module tb_ffm_frame_gate;

  localparam int MAX_INTERNAL_SPACE = 64;
  localparam int TIMEOUT_W          = 16;
  localparam int CNT_W              = 32;
  localparam int AW                 = $clog2(MAX_INTERNAL_SPACE);

  logic                 ACLK;
  logic                 ARESETN;
  logic                 Enable;
  logic [AW:0]          Delay;
  logic [TIMEOUT_W-1:0] Timeout;
  logic [AW:0]          FFSTail;
  logic                 S_AXIS_tvalid;
  logic                 S_AXIS_tlast;
  logic                 M_AXIS_tready;
  logic                 M_AXIS_tvalid;
  logic                 S_AXIS_tready;
  logic                 Gate_open;
  logic [CNT_W-1:0]     Frames_released;
  logic [CNT_W-1:0]     Timeout_releases;

  int checks = 0;
  int errors = 0;

  ffm_frame_gate #(
    .MAX_INTERNAL_SPACE (MAX_INTERNAL_SPACE),
    .TIMEOUT_W          (TIMEOUT_W),
    .CNT_W              (CNT_W)
  ) dut (
    .ACLK             (ACLK),
    .ARESETN          (ARESETN),
    .Enable           (Enable),
    .Delay            (Delay),
    .Timeout          (Timeout),
    .FFSTail          (FFSTail),
    .S_AXIS_tvalid    (S_AXIS_tvalid),
    .S_AXIS_tlast     (S_AXIS_tlast),
    .M_AXIS_tready    (M_AXIS_tready),
    .M_AXIS_tvalid    (M_AXIS_tvalid),
    .S_AXIS_tready    (S_AXIS_tready),
    .Gate_open        (Gate_open),
    .Frames_released  (Frames_released),
    .Timeout_releases (Timeout_releases)
  );

  // Clock / reset
  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic cyc();
    @(negedge ACLK);
  endtask

  // Holds reset for two cycles and releases it on a falling edge; the
  // caller is then in the first post-reset cycle (wait_cnt = 0).
  task automatic do_reset();
    ARESETN = 1'b0;
    repeat (2) cyc();
    ARESETN = 1'b1;
  endtask

  // Checkers
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic mv, input logic sr, input logic go);
    chk({tag, ".m_tvalid"}, 32'(M_AXIS_tvalid), 32'(mv));
    chk({tag, ".s_tready"}, 32'(S_AXIS_tready), 32'(sr));
    chk({tag, ".gate_open"}, 32'(Gate_open), 32'(go));
  endtask

  initial begin
    int beat;
    logic tr;

    ARESETN       = 1'b0;
    Enable        = 1'b1;
    Delay         = 7'd8;
    Timeout       = '0;
    FFSTail       = '0;
    S_AXIS_tvalid = 1'b1;
    S_AXIS_tlast  = 1'b0;
    M_AXIS_tready = 1'b1;

    // ---- Reset state (valid/ready driven high to show they are gated) ----
    repeat (3) cyc();
    #1;
    chk_out("rst", 1'b0, 1'b0, 1'b0);
    chk("rst.frames", Frames_released, 32'd0);
    chk("rst.tmo", Timeout_releases, 32'd0);

    // ---- Threshold release: Delay=8, FFSTail reaches 8 at cycle 20 ----
    cyc();
    ARESETN = 1'b1;
    #1 chk_out("thr.c0", 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 20; i++) begin
      cyc();
      #1 chk_out("thr.wait", 1'b0, 1'b0, 1'b0);
    end
    cyc(); FFSTail = 7'd8;
    #1 chk_out("thr.c20", 1'b0, 1'b0, 1'b0);
    cyc();
    #1 chk_out("thr.b0", 1'b1, 1'b1, 1'b1);
    cyc();
    #1 chk_out("thr.b1", 1'b1, 1'b1, 1'b1);
    cyc(); S_AXIS_tlast = 1'b1;
    #1 chk_out("thr.b2", 1'b1, 1'b1, 1'b1);
    cyc(); S_AXIS_tlast = 1'b0;
    #1 chk_out("thr.closed", 1'b0, 1'b0, 1'b0);
    chk("thr.frames", Frames_released, 32'd1);
    chk("thr.tmo", Timeout_releases, 32'd0);

    // ---- Timeout release: Delay=40, FFSTail=5, Timeout=10 ----
    Delay = 7'd40; FFSTail = 7'd5; Timeout = 16'd10;
    S_AXIS_tvalid = 1'b0; S_AXIS_tlast = 1'b0; M_AXIS_tready = 1'b1;
    do_reset();
    #1 chk("tmo.c0", 32'(Gate_open), 32'd0);
    for (int i = 1; i < 10; i++) begin
      cyc();
      #1 chk("tmo.wait", 32'(Gate_open), 32'd0);
    end
    cyc(); S_AXIS_tvalid = 1'b1;
    #1 chk_out("tmo.open", 1'b1, 1'b1, 1'b1);
    chk("tmo.cnt1", Timeout_releases, 32'd1);
    cyc(); S_AXIS_tlast = 1'b1;
    #1 chk_out("tmo.last", 1'b1, 1'b1, 1'b1);
    cyc(); S_AXIS_tvalid = 1'b0; S_AXIS_tlast = 1'b0;
    #1 chk("tmo.closed", 32'(Gate_open), 32'd0);
    chk("tmo.frames", Frames_released, 32'd1);
    chk("tmo.cnt_after", Timeout_releases, 32'd1);
    for (int i = 1; i < 10; i++) begin
      cyc();
      #1 chk("tmo.rewait", 32'(Gate_open), 32'd0);
    end
    cyc();
    #1 chk("tmo.reopen", 32'(Gate_open), 32'd1);
    cyc();
    #1 chk("tmo.cnt2", Timeout_releases, 32'd2);

    // ---- Back-to-back frames with tready toggling ----
    Delay = 7'd1; FFSTail = 7'd64; Timeout = '0;
    S_AXIS_tvalid = 1'b0; S_AXIS_tlast = 1'b0; M_AXIS_tready = 1'b1;
    do_reset();
    #1 chk("b2b.c0", 32'(Gate_open), 32'd0);
    cyc();
    for (int f = 0; f < 2; f++) begin
      beat = 0;
      tr   = 1'b1;
      while (beat < 4) begin
        S_AXIS_tvalid = 1'b1;
        S_AXIS_tlast  = (beat == 3);
        M_AXIS_tready = tr;
        #1 chk_out("b2b.beat", 1'b1, tr, 1'b1);
        if (tr) beat++;
        tr = ~tr;
        cyc();
      end
      S_AXIS_tvalid = 1'b1; S_AXIS_tlast = 1'b0; M_AXIS_tready = 1'b1;
      #1 chk_out("b2b.gap", 1'b0, 1'b0, 1'b0);
      chk("b2b.frames", Frames_released, 32'(f + 1));
      cyc();
    end
    S_AXIS_tvalid = 1'b0;
    #1 chk("b2b.reopen", 32'(Gate_open), 32'd1);

    // ---- Enable toggling mid-frame ----
    Enable = 1'b1; Delay = 7'd5; FFSTail = 7'd5; Timeout = '0;
    S_AXIS_tvalid = 1'b0; S_AXIS_tlast = 1'b0; M_AXIS_tready = 1'b1;
    do_reset();
    #1 chk("en.c0", 32'(Gate_open), 32'd0);
    cyc(); S_AXIS_tvalid = 1'b1; Enable = 1'b0;
    #1 chk_out("en.open_b0", 1'b1, 1'b1, 1'b1);
    cyc(); FFSTail = 7'd0;
    #1 chk_out("en.open_b1", 1'b1, 1'b1, 1'b1);
    cyc(); S_AXIS_tlast = 1'b1;
    #1 chk_out("en.open_b2", 1'b1, 1'b1, 1'b1);
    cyc(); S_AXIS_tlast = 1'b0; Enable = 1'b1;
    #1 chk_out("en.byp_b0", 1'b1, 1'b1, 1'b1);
    chk("en.frames1", Frames_released, 32'd1);
    cyc();
    #1 chk_out("en.byp_b1", 1'b1, 1'b1, 1'b1);
    cyc(); S_AXIS_tlast = 1'b1;
    #1 chk_out("en.byp_b2", 1'b1, 1'b1, 1'b1);
    cyc(); S_AXIS_tlast = 1'b0;
    #1 chk_out("en.closed", 1'b0, 1'b0, 1'b0);
    chk("en.frames_byp", Frames_released, 32'd1);
    cyc(); Enable = 1'b0;
    #1 chk_out("en.blk_dis", 1'b0, 1'b0, 1'b0);
    cyc();
    #1 chk_out("en.byp_idle", 1'b1, 1'b1, 1'b1);
    cyc(); Enable = 1'b1; S_AXIS_tlast = 1'b1;
    #1 chk_out("en.byp_last", 1'b1, 1'b1, 1'b1);
    cyc(); S_AXIS_tlast = 1'b0;
    #1 chk_out("en.byp_closed", 1'b0, 1'b0, 1'b0);
    chk("en.tmo", Timeout_releases, 32'd0);

    // ---- Boundaries: Delay=0, counter saturation, reset mid-frame ----
    Enable = 1'b1; Delay = 7'd0; FFSTail = 7'd0; Timeout = '0;
    S_AXIS_tvalid = 1'b0; S_AXIS_tlast = 1'b0; M_AXIS_tready = 1'b1;
    do_reset();
    #1 chk("bnd.c0", 32'(Gate_open), 32'd0);
    cyc();
    #1 chk("bnd.delay0", 32'(Gate_open), 32'd1);
    force dut.u_frames_cnt.cnt_q = '1;
    #1 release dut.u_frames_cnt.cnt_q;
    #1 chk("bnd.preload", Frames_released, 32'hFFFF_FFFF);
    S_AXIS_tvalid = 1'b1; S_AXIS_tlast = 1'b1;
    #1 chk_out("bnd.single", 1'b1, 1'b1, 1'b1);
    cyc(); S_AXIS_tlast = 1'b0;
    #1 chk_out("bnd.single_closed", 1'b0, 1'b0, 1'b0);
    chk("bnd.sat", Frames_released, 32'hFFFF_FFFF);
    cyc();
    #1 chk_out("bnd.mid_b0", 1'b1, 1'b1, 1'b1);
    cyc(); ARESETN = 1'b0;
    #1 chk_out("bnd.rst_edge", 1'b1, 1'b1, 1'b1);
    cyc();
    #1 chk_out("bnd.rst_closed", 1'b0, 1'b0, 1'b0);
    chk("bnd.rst_frames", Frames_released, 32'd0);
    chk("bnd.rst_tmo", Timeout_releases, 32'd0);
    ARESETN = 1'b1;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_ffm_frame_gate
